// File: rtl/cla4_adder_pkg.sv
// Shared constants for the 4-bit carry-lookahead adder slice.
package cla4_adder_pkg;

    localparam int unsigned CLA_WIDTH = 4;

endpackage : cla4_adder_pkg

// File: rtl/cla4_adder_if.sv
// Operand/result bundle for one carry-lookahead slice; master drives operands, slave returns results.
interface cla4_adder_if;

    logic [cla4_adder_pkg::CLA_WIDTH-1:0] A;
    logic [cla4_adder_pkg::CLA_WIDTH-1:0] B;
    logic                                 Ci;
    logic [cla4_adder_pkg::CLA_WIDTH-1:0] S;
    logic                                 Co;
    logic                                 PG;
    logic                                 GG;

    modport master (
        output A, B, Ci,
        input  S, Co, PG, GG
    );

    modport slave (
        input  A, B, Ci,
        output S, Co, PG, GG
    );

endinterface : cla4_adder_if

// File: rtl/cla4_core.sv
// Purely combinational 4-bit lookahead: bit propagate/generate, flat carry equations,
// and group PG/GG for a second-level lookahead unit.
module cla4_core
    import cla4_adder_pkg::*;
(
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 ci,
    output logic [CLA_WIDTH-1:0] s,
    output logic                 co,
    output logic                 pg,
    output logic                 gg
);

    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] g;
    logic [CLA_WIDTH-1:0] c;

    for (genvar i = 0; i < CLA_WIDTH; i++) begin : g_bit
        assign p[i] = a[i] ^ b[i];
        assign g[i] = a[i] & b[i];
    end

    // Every carry is a two-level sum of products; no carry depends on another carry.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign co = gg | (pg & ci);

    assign s = p ^ c;

endmodule : cla4_core

// File: rtl/cla4_adder.sv
// 4-bit carry-lookahead adder slice: combinational lookahead core followed by a single
// output register stage cleared asynchronously by rst.
module cla4_adder
    import cla4_adder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cla4_adder_if.slave  bus
);

    logic [CLA_WIDTH-1:0] s_c;
    logic                 co_c;
    logic                 pg_c;
    logic                 gg_c;

    cla4_core u_core (
        .a  (bus.A),
        .b  (bus.B),
        .ci (bus.Ci),
        .s  (s_c),
        .co (co_c),
        .pg (pg_c),
        .gg (gg_c)
    );

    // Output stage; reset clears results immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.S  <= '0;
            bus.Co <= 1'b0;
            bus.PG <= 1'b0;
            bus.GG <= 1'b0;
        end else begin
            bus.S  <= s_c;
            bus.Co <= co_c;
            bus.PG <= pg_c;
            bus.GG <= gg_c;
        end
    end

endmodule : cla4_adder

// File: tb/tb_cla4_adder.sv
// Self-checking bench for cla4_adder: directed vector table, reset/pipeline sequences,
// exhaustive sweep and random vectors against an arithmetic reference model.
module tb_cla4_adder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cla4_adder_if bus ();

    cla4_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
        logic       pg;
        logic       gg;
    } vec_t;

    // Reference: {S, Co, PG, GG} from plain integer arithmetic.
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int unsigned ab;
        int unsigned tot;
        ab  = 32'(a) + 32'(b);
        tot = ab + 32'(ci);
        return {4'(tot), (tot > 15), ((a ^ b) == 4'hF), (ab > 15)};
    endfunction

    task automatic check(input string name, input logic [3:0] es, input logic eco,
                         input logic epg, input logic egg);
        checks++;
        if ({bus.S, bus.Co, bus.PG, bus.GG} !== {es, eco, epg, egg}) begin
            errors++;
            $display("FAIL %s: got S=%h Co=%b PG=%b GG=%b, required S=%h Co=%b PG=%b GG=%b",
                     name, bus.S, bus.Co, bus.PG, bus.GG, es, eco, epg, egg);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
        bus.A  = a;
        bus.B  = b;
        bus.Ci = ci;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name, input logic [3:0] a, input logic [3:0] b,
                               input logic ci);
        logic [6:0] e;
        e = model(a, b, ci);
        check(name, e[6:3], e[2], e[1], e[0]);
    endtask

    vec_t vecs[6];

    initial begin
        logic [3:0] ra, rb;
        logic       rci;
        logic [8:0] sweep;

        checks = 0;
        errors = 0;

        vecs[0] = '{"zero",       4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"prop_thru",  4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"gen_msb",    4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"alt_prop",   4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"max",        4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"prop_noci",  4'hC, 4'h3, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};

        // Reset holds outputs at zero with no clock edge needed.
        rst = 1'b1;
        drive(4'hF, 4'hF, 1'b1);
        #2;
        check("reset_async", 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("reset_held", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check("post_reset_first", 4'hF, 1'b1, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].ci);
            step();
            check(vecs[i].name, vecs[i].s, vecs[i].co, vecs[i].pg, vecs[i].gg);
        end

        // Back-to-back operands on consecutive edges.
        drive(4'd3, 4'd4, 1'b0);
        step();
        check("pipe_0", 4'd7, 1'b0, 1'b0, 1'b0);
        drive(4'd7, 4'd9, 1'b1);
        step();
        check("pipe_1", 4'd1, 1'b1, 1'b0, 1'b1);
        drive(4'd1, 4'd1, 1'b0);
        step();
        check("pipe_2", 4'd2, 1'b0, 1'b0, 1'b0);

        // Reset asserted between edges while S=9.
        drive(4'd4, 4'd5, 1'b0);
        step();
        check("pre_midreset", 4'h9, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_async", 4'h0, 1'b0, 1'b0, 1'b0);
        drive(4'd2, 4'd3, 1'b0);
        step();
        check("midreset_held", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(4'd6, 4'd7, 1'b1);
        step();
        check("midreset_release", 4'hE, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep, one combination per cycle.
        for (int i = 0; i < 512; i++) begin
            sweep = 9'(i);
            drive(sweep[8:5], sweep[4:1], sweep[0]);
            step();
            check_model("sweep", sweep[8:5], sweep[4:1], sweep[0]);
        end

        // Random vectors.
        for (int i = 0; i < 300; i++) begin
            ra  = 4'($urandom_range(15, 0));
            rb  = 4'($urandom_range(15, 0));
            rci = 1'($urandom_range(1, 0));
            drive(ra, rb, rci);
            step();
            check_model("random", ra, rb, rci);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cla4_adder

// File: doc/cla4_adder.md
Name: cla4_adder

Overview:
- 4-bit carry-lookahead adder slice with a single registered output stage.
- Produces the sum and carry-out, plus group propagate (PG) and group generate (GG) so that several slices can be cascaded under a second-level lookahead unit.
- Lookahead logic is purely combinational; all outputs are registered on the rising clock edge.

Parameters:
- none (width fixed at 4 bits)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- A    input  4  operand A, unsigned
- B    input  4  operand B, unsigned
- Ci   input  1  carry in
- S    output 4  registered sum, (A+B+Ci) mod 16
- Co   output 1  registered carry out
- PG   output 1  registered group propagate
- GG   output 1  registered group generate

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- While rst=1, S=0, Co=0, PG=0 and GG=0 immediately, regardless of clk.
- After rst deasserts, the first rising edge of clk captures valid results.
- Bit cells, for i=0..3: p_i = A_i XOR B_i; g_i = A_i AND B_i.
- Carries use lookahead form, not a ripple chain:
  - c0 = Ci
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
- Group signals:
  - PG = p3·p2·p1·p0
  - GG = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - Co = GG | PG·Ci
- Sum: S_i = p_i XOR c_i.
- Required identity: {Co,S} = A + B + Ci, a 5-bit result; the maximum is 15+15+1 = 31 = 5'b11111.
- PG and GG do not depend on Ci.
- Latency: exactly 1 clock. Outputs at edge n reflect the inputs sampled at edge n.
- No enable and no handshake; a new operand pair is accepted every cycle.
- Inputs must be stable during the setup/hold window; the combinational path is registered only at the outputs.
- Reset asserted mid-stream clears the outputs at once. The first post-reset edge loads the current inputs; no stale value survives reset.
- X/Z on inputs is not handled specially.

Decomposition:
- Shared package: constant CLA_WIDTH = 4. No typedefs needed.
- One natural sub-module: cla4_core, the purely combinational lookahead. It takes A, B and Ci and returns S, Co, PG and GG.
- cla4_adder instantiates cla4_core and adds the output register with asynchronous reset.
- Per-bit p/g generation can be inline generate logic rather than a separate module.

Test Plan:
- Reset: assert rst with A=4'hF, B=4'hF, Ci=1. Required: S=0, Co=0, PG=0, GG=0 with no clock edge. Deassert rst, then one edge. Required: S=4'hF, Co=1, PG=0, GG=1.
- Zero and propagate-through: A=0, B=0, Ci=0, one edge. Required: S=0, Co=0, PG=0, GG=0. Then A=4'hF, B=0, Ci=1, one edge. Required: S=0, Co=1, PG=1, GG=0.
- Pure generate at MSB: A=4'h8, B=4'h8, Ci=0. Required: S=0, Co=1, PG=0, GG=1. Then A=4'h5, B=4'hA, Ci=0. Required: S=4'hF, Co=0, PG=1, GG=0.
- Exhaustive: sweep all 512 combinations of A, B and Ci, one per cycle. Each result must match {Co,S} = A+B+Ci one cycle later. PG must equal (A^B)==4'hF. GG must equal (A+B)>15.
- Back-to-back pipelining: apply A=3,B=4,Ci=0, then A=7,B=9,Ci=1, then A=1,B=1,Ci=0 on consecutive edges. Required outputs on consecutive edges: S=7/Co=0, then S=1/Co=1, then S=2/Co=0.
- Reset mid-stream: assert rst asynchronously between edges while S=4'h9. S must go to 0 before the next edge. It stays 0 until rst drops, then holds A+B+Ci of the inputs present at the first following edge.
